memory_responder: RTL and testbench

- Memory-side responder for the processor's READ/WRITE strobes.
- Services word reads and writes against an internal backing array and inserts a programmable number of wait states.
- Signals completion with a READY pulse inside a 4-phase handshake, so the control unit can stall its MEM/FETCH states.
- Sits between the data path's address/data buses and main storage.

---
 rtl/memory_responder_pkg.sv | 16 +
 rtl/memory_responder_wait_counter.sv | 28 ++
 rtl/memory_responder.sv | 140 ++++++++++++++
 tb/tb_memory_responder.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_responder_pkg.sv
// Shared definitions for the memory responder: FSM state encodings and
// default geometry/timing constants.
package memory_responder_pkg;

    typedef enum logic [2:0] {
        MEM_IDLE   = 3'd0,
        MEM_WAIT   = 3'd1,
        MEM_ACCESS = 3'd2,
        MEM_DONE   = 3'd3
    } mem_state_t;

    localparam int DATA_INDEX_LIMIT = 32;
    localparam int MEM_DEPTH_LOG2   = 10;
    localparam int MEM_WAIT_CYCLES  = 2;

endpackage

// File: rtl/memory_responder_wait_counter.sv
// Loadable down-counter that times the wait states of one memory access;
// done is high whenever the count has reached zero.
module memory_responder_wait_counter #(
    parameter int CNT_W = 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic             en,
    input  logic [CNT_W-1:0] load_val,
    output logic             done
);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (en && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/memory_responder.sv
// Memory-side responder: services READ/WRITE strobes against a word array with
// programmable wait states and a 4-phase READY handshake.
// Optional address range checking (ERR port) is enabled by MEM_RANGE_CHECK_EN.
module memory_responder
    import memory_responder_pkg::*;
#(
    parameter int ADDR_WIDTH  = 26,
    parameter int DATA_WIDTH  = DATA_INDEX_LIMIT,
    parameter int DEPTH_LOG2  = MEM_DEPTH_LOG2,
    parameter int WAIT_CYCLES = MEM_WAIT_CYCLES
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  READ,
    input  logic                  WRITE,
    input  logic [ADDR_WIDTH-1:0] ADDR,
    input  logic [DATA_WIDTH-1:0] DATA_IN,
    output logic [DATA_WIDTH-1:0] DATA_OUT,
    output logic                  READY,
    output logic                  BUSY
`ifdef MEM_RANGE_CHECK_EN
    ,
    output logic                  ERR
`endif
);

    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] LOAD_VAL =
        (WAIT_CYCLES > 0) ? CNT_W'(WAIT_CYCLES - 1) : '0;

    mem_state_t state_q, state_d;

    logic [DATA_WIDTH-1:0] mem [0:(2**DEPTH_LOG2)-1];

    logic                  op_write_q;
    logic [DEPTH_LOG2-1:0] idx_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic                  access_fault;

    logic req_ok;
    logic strobe_held;
    logic cnt_load, cnt_en, cnt_done;

    assign req_ok      = READ ^ WRITE;
    assign strobe_held = op_write_q ? WRITE : READ;

    memory_responder_wait_counter #(
        .CNT_W (CNT_W)
    ) u_wait_counter (
        .CLK      (CLK),
        .RST      (RST),
        .load     (cnt_load),
        .en       (cnt_en),
        .load_val (LOAD_VAL),
        .done     (cnt_done)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= MEM_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Abort in WAIT only looks at the strobe of the op that was accepted.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
        unique case (state_q)
            MEM_IDLE: begin
                if (req_ok) begin
                    cnt_load = 1'b1;
                    state_d  = (WAIT_CYCLES > 0) ? MEM_WAIT : MEM_ACCESS;
                end
            end
            MEM_WAIT: begin
                if (!strobe_held) begin
                    state_d = MEM_IDLE;
                end else if (cnt_done) begin
                    state_d = MEM_ACCESS;
                end else begin
                    cnt_en = 1'b1;
                end
            end
            MEM_ACCESS: state_d = MEM_DONE;
            MEM_DONE: begin
                if (!READ && !WRITE) begin
                    state_d = MEM_IDLE;
                end
            end
            default: state_d = MEM_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if ((state_q == MEM_IDLE) && req_ok) begin
            op_write_q <= WRITE;
            idx_q      <= ADDR[DEPTH_LOG2-1:0];
            wdata_q    <= DATA_IN;
        end
    end

`ifdef MEM_RANGE_CHECK_EN
    logic fault_q;

    always_ff @(posedge CLK) begin
        if ((state_q == MEM_IDLE) && req_ok) begin
            fault_q <= |ADDR[ADDR_WIDTH-1:DEPTH_LOG2];
        end
    end

    assign access_fault = fault_q;
    assign ERR          = (state_q == MEM_DONE) && fault_q;
`else
    logic addr_hi_unused;

    assign addr_hi_unused = |ADDR[ADDR_WIDTH-1:DEPTH_LOG2];
    assign access_fault   = 1'b0;
`endif

    always_ff @(posedge CLK) begin
        if ((state_q == MEM_ACCESS) && op_write_q && !access_fault) begin
            mem[idx_q] <= wdata_q;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            DATA_OUT <= '0;
        end else if ((state_q == MEM_ACCESS) && !op_write_q) begin
            DATA_OUT <= access_fault ? '0 : mem[idx_q];
        end
    end

    assign READY = (state_q == MEM_DONE);
    assign BUSY  = (state_q == MEM_WAIT) || (state_q == MEM_ACCESS);

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: two instances (2 wait states and 0 wait states)
// checked every cycle against a transaction-level model, plus directed literals.
`timescale 1ns/1ps
module tb_memory_responder;

    localparam int AW = 26;
    localparam int DW = 32;
    localparam int DL = 10;
    localparam int W0 = 2;
    localparam int W1 = 0;

    logic CLK = 1'b0;
    logic RST = 1'b0;

    logic          rd   [2];
    logic          wr   [2];
    logic [AW-1:0] addr [2];
    logic [DW-1:0] din  [2];
    logic [DW-1:0] dout [2];
    logic          rdy  [2];
    logic          bsy  [2];
`ifdef MEM_RANGE_CHECK_EN
    logic          err  [2];
    logic          last_err;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    always #5 CLK = ~CLK;

    memory_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .WAIT_CYCLES(W0)
    ) dut0 (
        .CLK(CLK), .RST(RST), .READ(rd[0]), .WRITE(wr[0]), .ADDR(addr[0]),
        .DATA_IN(din[0]), .DATA_OUT(dout[0]), .READY(rdy[0]), .BUSY(bsy[0])
`ifdef MEM_RANGE_CHECK_EN
        , .ERR(err[0])
`endif
    );

    memory_responder #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DEPTH_LOG2(DL), .WAIT_CYCLES(W1)
    ) dut1 (
        .CLK(CLK), .RST(RST), .READ(rd[1]), .WRITE(wr[1]), .ADDR(addr[1]),
        .DATA_IN(din[1]), .DATA_OUT(dout[1]), .READY(rdy[1]), .BUSY(bsy[1])
`ifdef MEM_RANGE_CHECK_EN
        , .ERR(err[1])
`endif
    );

    // ---------------- transaction-level model ----------------
    // A request accepted at edge 0 commits on edge W+1 unless its strobe has
    // dropped before then; READY then holds until both strobes are low.
    logic [DW-1:0] mm   [2][1024];
    bit            mk   [2][1024];
    bit            m_act [2];
    bit            m_dn  [2];
    bit            m_w   [2];
    bit            m_flt [2];
    int            m_age [2];
    logic [AW-1:0] m_a   [2];
    logic [DW-1:0] m_d   [2];
    bit   [DW-1:0] m_out [2];
    bit            m_out_k [2];

    function automatic int wc(input int d);
        return (d == 0) ? W0 : W1;
    endfunction

    function automatic bit fault_of(input logic [AW-1:0] a);
`ifdef MEM_RANGE_CHECK_EN
        return (a >> DL) != 0;
`else
        return (a == '1) && (a != '1);
`endif
    endfunction

    always @(posedge CLK or negedge RST) begin
        for (int d = 0; d < 2; d++) begin
            if (!RST) begin
                m_act[d]   <= 1'b0;
                m_dn[d]    <= 1'b0;
                m_out[d]   <= '0;
                m_out_k[d] <= 1'b1;
            end else if (!m_act[d]) begin
                if (rd[d] ^ wr[d]) begin
                    m_act[d] <= 1'b1;
                    m_age[d] <= 0;
                    m_w[d]   <= wr[d];
                    m_a[d]   <= addr[d];
                    m_d[d]   <= din[d];
                end
            end else if (!m_dn[d]) begin
                if ((m_age[d] < wc(d)) && !(m_w[d] ? wr[d] : rd[d])) begin
                    m_act[d] <= 1'b0;
                end else if (m_age[d] == wc(d)) begin
                    m_dn[d]  <= 1'b1;
                    m_flt[d] <= fault_of(m_a[d]);
                    if (m_w[d]) begin
                        if (!fault_of(m_a[d])) begin
                            mm[d][m_a[d][DL-1:0]] <= m_d[d];
                            mk[d][m_a[d][DL-1:0]] <= 1'b1;
                        end
                    end else if (fault_of(m_a[d])) begin
                        m_out[d]   <= '0;
                        m_out_k[d] <= 1'b1;
                    end else begin
                        m_out[d]   <= mm[d][m_a[d][DL-1:0]];
                        m_out_k[d] <= mk[d][m_a[d][DL-1:0]];
                    end
                end else begin
                    m_age[d] <= m_age[d] + 1;
                end
            end else if (!rd[d] && !wr[d]) begin
                m_act[d] <= 1'b0;
                m_dn[d]  <= 1'b0;
            end
        end
    end

    task automatic chk(input string nm, input int d, input logic [DW-1:0] act,
                       input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d: got %h expected %h at %0t", nm, d, act, exp, $time);
        end
    endtask

    // ---------------- per-cycle compare ----------------
    always @(negedge CLK) begin
        for (int d = 0; d < 2; d++) begin
            chk("model_ready", d, {31'b0, rdy[d]}, {31'b0, m_dn[d]});
            chk("model_busy", d, {31'b0, bsy[d]}, {31'b0, m_act[d] && !m_dn[d]});
            if (m_out_k[d]) chk("model_dout", d, dout[d], m_out[d]);
`ifdef MEM_RANGE_CHECK_EN
            chk("model_err", d, {31'b0, err[d]}, {31'b0, m_dn[d] && m_flt[d]});
`endif
        end
    end

    // One full handshake; inputs are scrambled right after sampling to show
    // they were latched. lat counts edges with the sampling edge as edge 1.
    task automatic access(input int d, input bit w, input logic [AW-1:0] a,
                          input logic [DW-1:0] v, input int hold,
                          output int lat, output int bc);
        @(posedge CLK); #1;
        addr[d] = a; din[d] = v; wr[d] = w; rd[d] = !w;
        lat = 0; bc = 0;
        do begin
            @(posedge CLK); #1;
            lat++;
            if (lat == 1) begin addr[d] = ~a; din[d] = ~v; end
            if (bsy[d]) bc++;
        end while (!rdy[d] && lat < 20);
        if (!rdy[d]) chk("ready_timeout", d, {31'b0, rdy[d]}, 32'd1);
`ifdef MEM_RANGE_CHECK_EN
        last_err = err[d];
`endif
        repeat (hold) begin
            @(posedge CLK); #1;
            chk("hold_ready", d, {31'b0, rdy[d]}, 32'd1);
        end
        rd[d] = 1'b0; wr[d] = 1'b0;
        @(posedge CLK); #1;
        chk("release_ready", d, {31'b0, rdy[d]}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, bc;
        for (int d = 0; d < 2; d++) begin
            rd[d] = 1'b0; wr[d] = 1'b0; addr[d] = '0; din[d] = '0;
        end
        repeat (3) @(posedge CLK);
        #1;
        for (int d = 0; d < 2; d++) begin
            chk("rst_ready", d, {31'b0, rdy[d]}, 32'd0);
            chk("rst_busy", d, {31'b0, bsy[d]}, 32'd0);
            chk("rst_dout", d, dout[d], 32'd0);
        end
        RST = 1'b1;

        // write then read, two wait states
        access(0, 1'b1, 26'h5, 32'hDEADBEEF, 0, lat, bc);
        chk("wr_latency", 0, lat, 32'd4);
        chk("wr_busy_cycles", 0, bc, 32'd3);
        access(0, 1'b0, 26'h5, 32'h0, 0, lat, bc);
        chk("rd_latency", 0, lat, 32'd4);
        chk("rd_data", 0, dout[0], 32'hDEADBEEF);

        // zero wait states
        access(1, 1'b1, 26'h3, 32'h12345678, 0, lat, bc);
        access(1, 1'b0, 26'h3, 32'h0, 0, lat, bc);
        chk("zw_latency", 1, lat, 32'd2);
        chk("zw_busy_cycles", 1, bc, 32'd1);
        chk("zw_data", 1, dout[1], 32'h12345678);

        // abort in WAIT: strobe drops one cycle after sampling
        access(0, 1'b1, 26'h7, 32'h0, 0, lat, bc);
        @(posedge CLK); #1;
        addr[0] = 26'h7; din[0] = 32'hAAAA5555; wr[0] = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        wr[0] = 1'b0;
        repeat (4) begin
            @(posedge CLK); #1;
            chk("abort_ready", 0, {31'b0, rdy[0]}, 32'd0);
        end
        access(0, 1'b0, 26'h7, 32'h0, 0, lat, bc);
        chk("abort_data", 0, dout[0], 32'h00000000);

        // asynchronous reset during WAIT of a write
        access(0, 1'b1, 26'h9, 32'h13579BDF, 0, lat, bc);
        access(0, 1'b0, 26'h9, 32'h0, 0, lat, bc);
        @(posedge CLK); #1;
        addr[0] = 26'h9; din[0] = 32'hFFFFFFFF; wr[0] = 1'b1;
        @(posedge CLK); #1;
        @(posedge CLK); #1;
        chk("pre_rst_busy", 0, {31'b0, bsy[0]}, 32'd1);
        #2 RST = 1'b0;
        #1;
        chk("async_rst_busy", 0, {31'b0, bsy[0]}, 32'd0);
        chk("async_rst_ready", 0, {31'b0, rdy[0]}, 32'd0);
        chk("async_rst_dout", 0, dout[0], 32'd0);
        wr[0] = 1'b0;
        @(posedge CLK); #3 RST = 1'b1;
        access(0, 1'b0, 26'h9, 32'h0, 0, lat, bc);
        chk("rst_keeps_array", 0, dout[0], 32'h13579BDF);

        // READ and WRITE together are ignored
        @(posedge CLK); #1;
        rd[0] = 1'b1; wr[0] = 1'b1; addr[0] = 26'h5;
        repeat (5) begin
            @(posedge CLK); #1;
            chk("conflict_ready", 0, {31'b0, rdy[0]}, 32'd0);
            chk("conflict_busy", 0, {31'b0, bsy[0]}, 32'd0);
        end
        rd[0] = 1'b0; wr[0] = 1'b0;

        // READY persists while READ is held
        access(0, 1'b0, 26'h5, 32'h0, 3, lat, bc);
        chk("hold_data", 0, dout[0], 32'hDEADBEEF);

`ifdef MEM_RANGE_CHECK_EN
        access(0, 1'b1, 26'h0, 32'hCAFEF00D, 0, lat, bc);
        access(0, 1'b1, 26'h400, 32'h1, 0, lat, bc);
        chk("range_wr_err", 0, {31'b0, last_err}, 32'd1);
        chk("range_err_clears", 0, {31'b0, err[0]}, 32'd0);
        access(0, 1'b0, 26'h0, 32'h0, 0, lat, bc);
        chk("range_no_write", 0, dout[0], 32'hCAFEF00D);
        access(0, 1'b0, 26'h400, 32'h0, 0, lat, bc);
        chk("range_rd_err", 0, {31'b0, last_err}, 32'd1);
        chk("range_rd_data", 0, dout[0], 32'h0);
`else
        access(0, 1'b1, 26'h405, 32'h0BADF00D, 0, lat, bc);
        access(0, 1'b0, 26'h5, 32'h0, 0, lat, bc);
        chk("alias_data", 0, dout[0], 32'h0BADF00D);
`endif

        repeat (2) @(posedge CLK);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
